idct_transpose_pp: RTL and testbench

Parametrised ping-pong transpose buffer that sits between the row and column passes of the IDCT datapath.
- Accepts square blocks of side 2^s in row-major order and emits each block in column-major (transposed) order.
- Block size is selectable per block and has valid/ready handshakes on both sides.
- Two banks let one block be written while the previous one is read, so throughput is one sample per cycle.

---
 rtl/idct_transpose_pp.sv | 279 +++++++++++++++++++++++++++
 tb/tb_idct_transpose_pp.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_transpose_pp.sv
// idct_transpose_pp
//   Ping-pong transpose buffer placed between the row and column IDCT passes.
//   Square blocks of side N = 2^S (S = 2..LOG2N_MAX) arrive in row-major order
//   and leave in column-major order. One bank fills while the other drains,
//   so a continuous stream moves one sample per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input sample valid
//   in_ready   buffer accepts a sample this cycle
//   in_sof     first sample of a block (in_size sampled here)
//   in_size    log2 of block side
//   in_data    input sample
//   out_valid  output sample valid
//   out_ready  downstream accepts the output sample
//   out_sof    first output sample of a block
//   out_eob    last output sample of a block
//   out_size   size tag of the block being output
//   out_data   output sample
//   err        sticky protocol-error flag (cleared only by rst)
module idct_transpose_pp #(
    parameter int WIDTH_X   = 16,
    parameter int LOG2N_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [2:0]         in_size,
    input  logic [WIDTH_X-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eob,
    output logic [2:0]         out_size,
    output logic [WIDTH_X-1:0] out_data,
    output logic               err
);

    localparam int AW    = 2 * LOG2N_MAX;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_READING
    } bank_st_e;

    typedef struct packed {
        logic [WIDTH_X-1:0] data;
        logic               sof;
        logic               eob;
        logic [2:0]         size;
    } ent_t;

    // Bank bookkeeping
    bank_st_e   st_q  [2];
    bank_st_e   st_d  [2];
    logic [2:0] tag_q [2];
    logic [2:0] tag_d [2];

    // Write side
    logic          wp_q, wp_d;
    logic [AW:0]   k_q, k_d;
    logic [2:0]    s_q, s_d;
    logic          err_q, err_d;

    // Read side
    logic          rp_q, rp_d;
    logic [AW-1:0] j_q, j_d;

    // Read pipeline stage (memory output)
    logic               rv_q;
    logic               r_sof_q, r_eob_q;
    logic [2:0]         r_size_q;
    logic [WIDTH_X-1:0] rdata_q;

    // Output skid buffer, entry 0 drives the outputs
    ent_t       fifo_q [2];
    ent_t       fifo_d [2];
    logic [1:0] cnt_q, cnt_d;

    logic [WIDTH_X-1:0] mem [0:2*DEPTH-1];

    // Write-side combinational signals
    logic          wr_fire;
    logic [2:0]    size_clamp;
    logic          size_bad;
    logic [AW:0]   blk_len;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    // Read-side combinational signals
    logic [2:0]    rtag;
    logic          rd_avail;
    logic          rd_issue;
    logic          rlast;
    logic [AW:0]   rd_len;
    logic [AW-1:0] col_mask, rcol, rrow, raddr;
    logic [2:0]    occ;
    logic          pop;
    ent_t          new_ent;

    assign in_ready = !rst && (st_q[wp_q] == B_EMPTY || st_q[wp_q] == B_FILLING);
    assign wr_fire  = in_valid && in_ready;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_q[0].data;
    assign out_size  = fifo_q[0].size;
    assign out_sof   = out_valid && fifo_q[0].sof;
    assign out_eob   = out_valid && fifo_q[0].eob;
    assign err       = err_q;

    assign pop = out_valid && out_ready;

    // Size clamping
    always_comb begin
        size_clamp = in_size;
        size_bad   = 1'b0;
        if (in_size < 3'd2) begin
            size_clamp = 3'd2;
            size_bad   = 1'b1;
        end else if (in_size > 3'(LOG2N_MAX)) begin
            size_clamp = 3'(LOG2N_MAX);
            size_bad   = 1'b1;
        end
    end

    assign blk_len = (AW+1)'(1) << {s_q, 1'b0};

    // Transposed read address: output j maps to input (j mod N)*N + j div N
    assign rtag     = tag_q[rp_q];
    assign rd_len   = (AW+1)'(1) << {rtag, 1'b0};
    assign col_mask = ((AW)'(1) << rtag) - (AW)'(1);
    assign rcol     = j_q & col_mask;
    assign rrow     = j_q >> rtag;
    assign raddr    = (rcol << rtag) | rrow;
    assign rlast    = ({1'b0, j_q} == (rd_len - (AW+1)'(1)));
    assign rd_avail = (st_q[rp_q] == B_FULL) || (st_q[rp_q] == B_READING);

    // Credit check: buffered entries plus the read in flight, minus the one
    // leaving this cycle, must leave room for the read issued now.
    assign occ      = 3'(cnt_q) + 3'(rv_q) - 3'(pop);
    assign rd_issue = rd_avail && (occ < 3'd2);

    assign new_ent = '{data: rdata_q, sof: r_sof_q, eob: r_eob_q, size: r_size_q};

    // Bank / pointer next state. Writer only touches EMPTY/FILLING banks and
    // reader only FULL/READING banks, so the two never collide on one bank.
    always_comb begin
        st_d      = st_q;
        tag_d     = tag_q;
        wp_d      = wp_q;
        k_d       = k_q;
        s_d       = s_q;
        err_d     = err_q;
        rp_d      = rp_q;
        j_d       = j_q;
        mem_we    = 1'b0;
        mem_waddr = '0;

        if (wr_fire) begin
            if (in_sof) begin
                // A new SOF mid-block discards the partial block.
                if (size_bad || k_q != '0) begin
                    err_d = 1'b1;
                end
                s_d          = size_clamp;
                mem_we       = 1'b1;
                mem_waddr    = '0;
                k_d          = (AW+1)'(1);
                st_d[wp_q]   = B_FILLING;
            end else if (k_q == '0) begin
                err_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = k_q[AW-1:0];
                if (k_q + (AW+1)'(1) == blk_len) begin
                    st_d[wp_q]  = B_FULL;
                    tag_d[wp_q] = s_q;
                    wp_d        = !wp_q;
                    k_d         = '0;
                end else begin
                    k_d = k_q + (AW+1)'(1);
                end
            end
        end

        if (rd_issue) begin
            if (rlast) begin
                st_d[rp_q] = B_EMPTY;
                rp_d       = !rp_q;
                j_d        = '0;
            end else begin
                st_d[rp_q] = B_READING;
                j_d        = j_q + (AW)'(1);
            end
        end
    end

    // Skid buffer next state
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        case ({rv_q, pop})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    fifo_d[0] = new_ent;
                end else begin
                    fifo_d[0] = fifo_q[1];
                    fifo_d[1] = new_ent;
                end
            end
            2'b01: begin
                fifo_d[0] = fifo_q[1];
                cnt_d     = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    fifo_d[0] = new_ent;
                end else begin
                    fifo_d[1] = new_ent;
                end
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Sample storage and synchronous read port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{wp_q, mem_waddr}] <= in_data;
        end
        if (rd_issue) begin
            rdata_q <= mem[{rp_q, raddr}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= '{default: B_EMPTY};
            tag_q    <= '{default: 3'd0};
            wp_q     <= 1'b0;
            k_q      <= '0;
            s_q      <= 3'd2;
            err_q    <= 1'b0;
            rp_q     <= 1'b0;
            j_q      <= '0;
            rv_q     <= 1'b0;
            r_sof_q  <= 1'b0;
            r_eob_q  <= 1'b0;
            r_size_q <= 3'd0;
            fifo_q   <= '{default: '0};
            cnt_q    <= 2'd0;
        end else begin
            st_q     <= st_d;
            tag_q    <= tag_d;
            wp_q     <= wp_d;
            k_q      <= k_d;
            s_q      <= s_d;
            err_q    <= err_d;
            rp_q     <= rp_d;
            j_q      <= j_d;
            rv_q     <= rd_issue;
            if (rd_issue) begin
                r_sof_q  <= (j_q == '0);
                r_eob_q  <= rlast;
                r_size_q <= rtag;
            end
            fifo_q   <= fifo_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_idct_transpose_pp.sv
// Testbench for idct_transpose_pp: random block contents checked against a
// matrix-transpose reference model.
module tb_idct_transpose_pp;

    localparam int W = 16;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [2:0]   in_size = 3'd0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic         out_sof;
    logic         out_eob;
    logic [2:0]   out_size;
    logic [W-1:0] out_data;
    logic         err;

    idct_transpose_pp #(.WIDTH_X(W), .LOG2N_MAX(L)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_size(in_size), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eob(out_eob), .out_size(out_size), .out_data(out_data),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sof;
        logic         eob;
        logic [2:0]   size;
    } smp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    smp_t exp_q[$];
    smp_t obs_q[$];
    int   obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer (the following rising edge completes it).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back(smp_t'{out_data, out_sof, out_eob, out_size});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: view the block as an N x N matrix, emit it column by column.
    task automatic model_block(input int s, input logic [W-1:0] vals[$]);
        int n = 1 << s;
        for (int c = 0; c < n; c++)
            for (int r = 0; r < n; r++)
                exp_q.push_back(smp_t'{vals[r*n+c], (c == 0 && r == 0),
                                       (c == n-1 && r == n-1), 3'(s)});
    endtask

    task automatic seq_vals(input int start, input int cnt, output logic [W-1:0] q[$]);
        q.delete();
        for (int i = 0; i < cnt; i++) q.push_back(W'(start + i));
    endtask

    task automatic rand_vals(input int cnt, output logic [W-1:0] q[$]);
        q.delete();
        for (int i = 0; i < cnt; i++) q.push_back(W'($urandom));
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push_sample(input logic sof, input logic [2:0] sz, input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1; in_sof = sof; in_size = sz; in_data = d;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                last_acc = cyc;
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t > 3000) begin
                checks++; errors++;
                $display("FAIL push_timeout: in_ready stayed 0, required 1 within 3000 cycles");
                break;
            end
        end
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_block(input logic [2:0] sz, input logic [W-1:0] vals[$]);
        for (int i = 0; i < vals.size(); i++) push_sample(i == 0, sz, vals[i]);
    endtask

    task automatic wait_drain(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 5000) begin
            @(posedge clk); t++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        checks++; if (out_data !== '0 || out_size !== 3'd0) begin errors++; $display("FAIL reset_data_size: got %h/%0d required 0/0", out_data, out_size); end
        checks++; if (out_sof !== 1'b0 || out_eob !== 1'b0) begin errors++; $display("FAIL reset_markers: got %b%b required 00", out_sof, out_eob); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_4x4();
        logic [W-1:0] v[$];
        clear_q();
        seq_vals(0, 16, v);
        model_block(2, v);
        send_block(3'd2, v);
        wait_drain(exp_q.size());
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t4x4_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t4x4_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_cyc.size() == 0 || obs_cyc[0] !== last_acc + 2) begin
            errors++; $display("FAIL t4x4_latency: first output after edge %0d, required after edge %0d",
                               (obs_cyc.size() == 0) ? -1 : obs_cyc[0], last_acc + 2);
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4x4_err: got %b required 0", err); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a[$];
        logic [W-1:0] b[$];
        int gaps = 0;
        clear_q();
        seq_vals(0, 64, a);
        seq_vals(100, 16, b);
        model_block(3, a);
        model_block(2, b);
        send_block(3'd3, a);
        send_block(3'd2, b);
        wait_drain(exp_q.size());
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) gaps++;
        checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_bubbles: got %0d idle gaps required 0", gaps); end
    endtask

    task automatic test_random_ready();
        logic [W-1:0] a[$];
        logic [W-1:0] b[$];
        logic [W-1:0] c[$];
        bit stop = 1'b0;
        clear_q();
        rand_vals(64, a); rand_vals(64, b); rand_vals(64, c);
        model_block(3, a); model_block(3, b); model_block(3, c);
        out_ready = 1'b0;
        send_block(3'd3, a);
        send_block(3'd3, b);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rr_both_full_in_ready: got %b required 0", in_ready); end
        @(posedge clk); #1;
        fork
            begin
                send_block(3'd3, c);
                wait_drain(exp_q.size());
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    if (!stop) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(exp_q.size());
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_restart();
        logic [W-1:0] v[$];
        clear_q();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL restart_pre_err: got %b required 0", err); end
        for (int i = 0; i < 5; i++) push_sample(i == 0, 3'd2, W'(50 + i));
        seq_vals(200, 16, v);
        model_block(2, v);
        send_block(3'd2, v);
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL restart_err: got %b required 1", err); end
        @(posedge clk); #1;
        wait_drain(exp_q.size());
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL restart_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL restart_err_sticky: got %b required 1", err); end
    endtask

    task automatic test_size_err();
        logic [W-1:0] v[$];
        do_reset();
        clear_q();
        rand_vals(64, v);
        model_block(L, v);
        send_block(3'd7, v);
        wait_drain(exp_q.size());
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL size_err_flag: got %b required 1", err); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL size_err_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL size_err_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_drop();
        logic [W-1:0] v[$];
        do_reset();
        clear_q();
        push_sample(1'b0, 3'd2, W'(16'h1234));
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b required 1", err); end
        @(posedge clk); #1;
        rand_vals(16, v);
        model_block(2, v);
        send_block(3'd2, v);
        wait_drain(exp_q.size());
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL drop_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v[$];
        int t = 0;
        do_reset();
        clear_q();
        push_sample(1'b0, 3'd2, W'(0));
        rand_vals(64, v);
        send_block(3'd3, v);
        while (obs_q.size() < 5 && t < 500) begin @(posedge clk); t++; end
        #1;
        checks++; if (obs_q.size() < 5) begin errors++; $display("FAIL rmid_readout_start: got %0d outputs required >=5", obs_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready_rst: got %b required 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b required 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        clear_q();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rmid_leftover: got %0d outputs required 0", obs_q.size()); end
        rand_vals(16, v);
        model_block(2, v);
        send_block(3'd2, v);
        wait_drain(exp_q.size());
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_sample %0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_back_to_back();
        test_random_ready();
        test_restart();
        test_size_err();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
